// File: rtl/imm_rot_encoder.sv
`default_nettype none
// ============================================================================
// Module   : imm_rot_encoder
// Function : Iteratively encodes a 32-bit constant as a rotated immediate
//            {rotate_imm[3:0], immed_8[7:0]}, one rotation per cycle.
//            Optional MVN second pass: define IMM_ROT_ENC_MVN_EN.
// Revision : 1.0 - initial release
// ============================================================================
module imm_rot_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] value_in,
    output logic        busy,
    output logic        done,
    output logic        valid,
    output logic [11:0] shift_operand,
    output logic        inverted
);

    // S_PRIME is the registered-input cycle between accepting start and the k=0 test
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PRIME  = 2'd1,
        S_SEARCH = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_val;
    logic [3:0]  r_rot;
    logic        r_valid;
    logic [11:0] r_shift;
    logic [4:0]  w_sh;
    logic [31:0] w_cand;
    logic        w_hit;
    logic        w_last;

    // Shift by 32 yields zero, so k=0 needs no special case
    assign w_sh   = {r_rot, 1'b0};
    assign w_cand = (r_val << w_sh) | (r_val >> (6'd32 - {1'b0, w_sh}));
    assign w_hit  = (w_cand[31:8] == 24'd0);
    assign w_last = (r_rot == 4'd15);

`ifdef IMM_ROT_ENC_MVN_EN
    logic r_pass;
    logic r_inv;
    assign inverted = r_inv;
`else
    assign inverted = 1'b0;
`endif

    assign busy          = (r_state != S_IDLE);
    assign done          = (r_state == S_DONE);
    assign valid         = r_valid;
    assign shift_operand = r_shift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_nxt = S_PRIME;
            S_PRIME:  w_state_nxt = S_SEARCH;
            S_SEARCH: begin
                if (w_hit) begin
                    w_state_nxt = S_DONE;
                end else if (w_last) begin
`ifdef IMM_ROT_ENC_MVN_EN
                    w_state_nxt = r_pass ? S_DONE : S_SEARCH;
`else
                    w_state_nxt = S_DONE;
`endif
                end
            end
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_val   <= 32'd0;
            r_rot   <= 4'd0;
            r_valid <= 1'b0;
            r_shift <= 12'd0;
`ifdef IMM_ROT_ENC_MVN_EN
            r_pass  <= 1'b0;
            r_inv   <= 1'b0;
`endif
        end else begin
            if (r_state == S_IDLE && start) begin
                r_val  <= value_in;
                r_rot  <= 4'd0;
`ifdef IMM_ROT_ENC_MVN_EN
                r_pass <= 1'b0;
`endif
            end else if (r_state == S_SEARCH) begin
                if (w_hit) begin
                    r_valid <= 1'b1;
                    r_shift <= {r_rot, w_cand[7:0]};
`ifdef IMM_ROT_ENC_MVN_EN
                    r_inv   <= r_pass;
`endif
                end else if (!w_last) begin
                    r_rot <= r_rot + 4'd1;
                end else begin
`ifdef IMM_ROT_ENC_MVN_EN
                    if (!r_pass) begin
                        r_pass <= 1'b1;
                        r_val  <= ~r_val;
                        r_rot  <= 4'd0;
                    end else begin
                        r_valid <= 1'b0;
                        r_shift <= 12'd0;
                        r_inv   <= 1'b0;
                    end
`else
                    r_valid <= 1'b0;
                    r_shift <= 12'd0;
`endif
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imm_rot_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_rot_encoder
// Function : Self-checking bench for imm_rot_encoder against a search model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imm_rot_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] value_in = 32'd0;
    logic        busy;
    logic        done;
    logic        valid;
    logic [11:0] shift_operand;
    logic        inverted;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef IMM_ROT_ENC_MVN_EN
    localparam int PASSES = 2;
`else
    localparam int PASSES = 1;
`endif

    imm_rot_encoder dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .value_in     (value_in),
        .busy         (busy),
        .done         (done),
        .valid        (valid),
        .shift_operand(shift_operand),
        .inverted     (inverted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rol32(input logic [31:0] v, input int s);
        int t;
        t = s % 32;
        if (t == 0) return v;
        return (v << t) | (v >> (32 - t));
    endfunction

    // Reference: smallest rotate wins, plain pass before the inverted pass
    task automatic model(input logic [31:0] v, output logic ok, output logic [11:0] sh,
                         output logic inv, output int lat);
        logic [31:0] c;
        ok  = 1'b0;
        sh  = 12'd0;
        inv = 1'b0;
        lat = 16 * PASSES + 1;
        for (int p = 0; p < PASSES; p++) begin
            for (int k = 0; k < 16; k++) begin
                c = rol32((p == 1) ? ~v : v, 2 * k);
                if (!ok && c < 32'd256) begin
                    ok  = 1'b1;
                    sh  = {4'(k), c[7:0]};
                    inv = (p == 1);
                    lat = 16 * p + k + 2;
                end
            end
        end
    endtask

    // Issue one request; returns edges from start edge to done, and sampled outputs
    task automatic run_req(input logic [31:0] v, output int lat, output logic o_valid,
                           output logic [11:0] o_sh, output logic o_inv,
                           output logic o_busy_ok, output logic o_after);
        start    = 1'b1;
        value_in = v;
        @(posedge clk); #1;
        start    = 1'b0;
        value_in = $urandom;
        lat       = -1;
        o_busy_ok = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (!busy) o_busy_ok = 1'b0;
            if (done) begin
                lat = n;
                break;
            end
        end
        o_valid = valid;
        o_sh    = shift_operand;
        o_inv   = inverted;
        @(posedge clk); #1;
        o_after = done | busy;
    endtask

    task automatic test_reset();
        #2;
        n_tests++;
        if ({busy, done, valid, shift_operand, inverted} !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b done=%b valid=%b sh=%h inv=%b, want all 0",
                     busy, done, valid, shift_operand, inverted);
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [31:0] vec [5];
        logic [11:0] lit_sh [3];
        int          lit_lat [3];
        int lat, e_lat;
        logic ov, oi, bok, aft, e_ok, e_inv;
        logic [11:0] osh, e_sh;
        vec[0] = 32'h000000FF; vec[1] = 32'hFF000000; vec[2] = 32'hF000000F;
        vec[3] = 32'h00000102; vec[4] = 32'hFFFFFF00;
        lit_sh[0] = 12'h0FF; lit_sh[1] = 12'h4FF; lit_sh[2] = 12'h2FF;
        lit_lat[0] = 2; lit_lat[1] = 6; lit_lat[2] = 4;
        for (int i = 0; i < 5; i++) begin
            run_req(vec[i], lat, ov, osh, oi, bok, aft);
            model(vec[i], e_ok, e_sh, e_inv, e_lat);
            n_tests++;
            if (lat !== e_lat || ov !== e_ok || osh !== e_sh || oi !== e_inv) begin
                n_fail++;
                $display("FAIL directed_%0d (%h): got lat=%0d valid=%b sh=%h inv=%b, want lat=%0d valid=%b sh=%h inv=%b",
                         i, vec[i], lat, ov, osh, oi, e_lat, e_ok, e_sh, e_inv);
            end
            n_tests++;
            if (!bok || aft !== 1'b0) begin
                n_fail++;
                $display("FAIL handshake_%0d: got busy_ok=%b after_done=%b, want 1 and 0", i, bok, aft);
            end
            if (i < 3) begin
                n_tests++;
                if (osh !== lit_sh[i] || lat !== lit_lat[i] || ov !== 1'b1) begin
                    n_fail++;
                    $display("FAIL literal_%0d: got sh=%h lat=%0d valid=%b, want sh=%h lat=%0d valid=1",
                             i, osh, lat, ov, lit_sh[i], lit_lat[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic ov, oi, bok, aft;
        logic [11:0] osh;
        logic seen;
        run_req(32'h000000FF, lat, ov, osh, oi, bok, aft);
        start    = 1'b1;
        value_in = 32'h00000102;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({busy, done, valid, shift_operand, inverted} !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_mid: got busy=%b done=%b valid=%b sh=%h inv=%b, want all 0",
                     busy, done, valid, shift_operand, inverted);
        end
        @(posedge clk); @(posedge clk); #1;
        rst  = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1'b1;
        end
        n_tests++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_discard: got activity=%b, want 0", seen);
        end
        run_req(32'h000000AB, lat, ov, osh, oi, bok, aft);
        n_tests++;
        if (lat !== 2 || ov !== 1'b1 || osh !== 12'h0AB || oi !== 1'b0) begin
            n_fail++;
            $display("FAIL after_reset: got lat=%0d valid=%b sh=%h inv=%b, want lat=2 valid=1 sh=0ab inv=0",
                     lat, ov, osh, oi);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [11:0] osh;
        start    = 1'b1;
        value_in = 32'hFF000000;
        @(posedge clk); #1;
        value_in = 32'h000000AB;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = n;
                break;
            end
        end
        osh = shift_operand;
        n_tests++;
        if (lat !== 6 || osh !== 12'h4FF) begin
            n_fail++;
            $display("FAIL busy_ignore: got lat=%0d sh=%h, want lat=6 sh=4ff", lat, osh);
        end
        @(posedge clk); #1;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_done: got busy=%b done=%b, want 0 0", busy, done);
        end
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = n;
                break;
            end
        end
        n_tests++;
        if (lat !== 2 || shift_operand !== 12'h0AB || valid !== 1'b1) begin
            n_fail++;
            $display("FAIL second_request: got lat=%0d sh=%h valid=%b, want lat=2 sh=0ab valid=1",
                     lat, shift_operand, valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int lat, e_lat, rsh, bad, bad_rt;
        logic ov, oi, bok, aft, e_ok, e_inv;
        logic [11:0] osh, e_sh;
        logic [31:0] v, exp_v, rt;
        bad = 0;
        bad_rt = 0;
        for (int i = 0; i < 1000; i++) begin
            case ($urandom_range(0, 2))
                0:       v = $urandom;
                1:       v = rol32({24'd0, 8'($urandom)}, 32 - 2 * $urandom_range(0, 15));
                default: v = ~rol32({24'd0, 8'($urandom)}, 32 - 2 * $urandom_range(0, 15));
            endcase
            run_req(v, lat, ov, osh, oi, bok, aft);
            model(v, e_ok, e_sh, e_inv, e_lat);
            n_tests++;
            if (lat !== e_lat || ov !== e_ok || osh !== e_sh || oi !== e_inv || !bok || aft !== 1'b0) begin
                n_fail++;
                if (bad < 5)
                    $display("FAIL random (%h): got lat=%0d valid=%b sh=%h inv=%b, want lat=%0d valid=%b sh=%h inv=%b",
                             v, lat, ov, osh, oi, e_lat, e_ok, e_sh, e_inv);
                bad++;
            end
            if (ov === 1'b1) begin
                exp_v = oi ? ~v : v;
                rsh   = 32 - 2 * int'(osh[11:8]);
                rt    = rol32({24'd0, osh[7:0]}, rsh);
                n_tests++;
                if (rt !== exp_v) begin
                    n_fail++;
                    if (bad_rt < 5)
                        $display("FAIL round_trip (%h): got %h, want %h", v, rt, exp_v);
                    bad_rt++;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
